// File: rtl/control_suma_serie_pkg.sv
// Shared definitions for the serial nibble add/subtract sequencer:
// FSM encodings, opcode values and the signed-overflow rule.
package control_suma_serie_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // b_msb is the MSB of the operand as presented to the adder (after inversion for subtract)
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/control_suma_serie_if.sv
// Request/result bundle between the requesting controller and the serial adder sequencer.
interface control_suma_serie_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             ovf;

  modport master (
    output start, op, A, B, Ci,
    input  busy, done, Sum, Cout, ovf
  );

  modport slave (
    input  start, op, A, B, Ci,
    output busy, done, Sum, Cout, ovf
  );
endinterface

// File: rtl/sumador_4bit.sv
// Shared 4-bit ripple-carry adder datapath.
module sumador_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [4:0] c;

  assign c[0] = Ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign Sum[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];
endmodule

// File: rtl/control_suma_serie.sv
// WIDTH-bit add/subtract computed one nibble per clock, LSB nibble first,
// through a single shared sumador_4bit with a registered carry chain.
//
// state | meaning
// IDLE  | waiting for start; results from last operation held
// RUN   | one nibble per edge at index idx_q, carry kept in carry_q
// DONE  | one-cycle done pulse; start here chains a new operation
module control_suma_serie
  import control_suma_serie_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  control_suma_serie_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BASW = IDXW + 2;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("control_suma_serie: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t            state_q, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, cout_q, ovf_q;
  logic [IDXW-1:0]   idx_q;

  logic              accept, last_nib;
  logic [WIDTH-1:0]  b_sel;
  logic              c_sel;
  logic [BASW-1:0]   base;
  logic [3:0]        add_sum;
  logic              add_cout;

  assign base = {idx_q, 2'b00};

  sumador_4bit u_sumador (
    .A    (a_q[base +: 4]),
    .B    (b_q[base +: 4]),
    .Ci   (carry_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  // Subtract is A + ~B + 1, so the incoming carry is forced high and Ci is ignored
  always_comb begin
    b_sel = bus.B;
    c_sel = bus.Ci;
    if (bus.op == OP_SUB) begin
      b_sel = ~bus.B;
      c_sel = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    last_nib  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          last_nib  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        a_q     <= bus.A;
        b_q     <= b_sel;
        carry_q <= c_sel;
        idx_q   <= '0;
        sum_q   <= '0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (state_q == RUN) begin
        sum_q[base +: 4] <= add_sum;
        carry_q          <= add_cout;
        // Index parks on the last nibble instead of wrapping; start clears it
        if (!last_nib) begin
          idx_q <= idx_q + 1'b1;
        end else begin
          cout_q <= add_cout;
          ovf_q  <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], add_sum[3]);
        end
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_control_suma_serie.sv
// Directed self-checking bench for control_suma_serie at WIDTH=16.
module tb_control_suma_serie;
  import control_suma_serie_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  control_suma_serie_if #(.WIDTH(16)) bus ();

  control_suma_serie #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drives one operation and measures it; callers do the comparisons.
  // lat counts edges from the start edge (inclusive) to done visible.
  task automatic run_op(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                        input logic ci_i, output int lat, output int bcnt,
                        output logic [15:0] s, output logic c, output logic v);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op_i; bus.A = a_i; bus.B = b_i; bus.Ci = ci_i;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1; bcnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    s = bus.Sum; c = bus.Cout; v = bus.ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = OP_ADD; bus.A = '0; bus.B = '0; bus.Ci = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done); end
    checks++; if (bus.Sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h expected 0000", bus.Sum); end
    checks++; if (bus.Cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b expected 0", bus.Cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b expected 0", bus.ovf); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat, bcnt; logic [15:0] s; logic c, v;
    run_op(OP_ADD, 16'h1234, 16'h0FFF, 1'b0, lat, bcnt, s, c, v);
    checks++; if (s !== 16'h2233) begin errors++; $display("FAIL add_sum got %h expected 2233", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL add_cout got %b expected 0", c); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL add_ovf got %b expected 0", v); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency got %0d expected 5", lat); end
    checks++; if (bcnt !== 4) begin errors++; $display("FAIL add_busy_cycles got %0d expected 4", bcnt); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b expected 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_idle_busy got %b expected 0", bus.busy); end
    checks++; if (bus.Sum !== 16'h2233) begin errors++; $display("FAIL add_sum_held got %h expected 2233", bus.Sum); end
  endtask

  task automatic test_carry_chain();
    int lat, bcnt; logic [15:0] s; logic c, v;
    run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, lat, bcnt, s, c, v);
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL carry_b_sum got %h expected 0000", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL carry_b_cout got %b expected 1", c); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL carry_b_ovf got %b expected 0", v); end
    run_op(OP_ADD, 16'hFFFF, 16'h0000, 1'b1, lat, bcnt, s, c, v);
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL carry_ci_sum got %h expected 0000", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL carry_ci_cout got %b expected 1", c); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL carry_ci_ovf got %b expected 0", v); end
  endtask

  task automatic test_sub();
    int lat, bcnt; logic [15:0] s; logic c, v;
    run_op(OP_SUB, 16'h0005, 16'h0007, 1'b1, lat, bcnt, s, c, v);
    checks++; if (s !== 16'hFFFE) begin errors++; $display("FAIL sub_borrow_sum got %h expected fffe", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout got %b expected 0", c); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL sub_borrow_ovf got %b expected 0", v); end
    run_op(OP_SUB, 16'h0007, 16'h0005, 1'b0, lat, bcnt, s, c, v);
    checks++; if (s !== 16'h0002) begin errors++; $display("FAIL sub_sum got %h expected 0002", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL sub_cout got %b expected 1", c); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL sub_latency got %0d expected 5", lat); end
  endtask

  task automatic test_overflow();
    int lat, bcnt; logic [15:0] s; logic c, v;
    run_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, lat, bcnt, s, c, v);
    checks++; if (s !== 16'h8000) begin errors++; $display("FAIL ovf_add_sum got %h expected 8000", s); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL ovf_add_ovf got %b expected 1", v); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL ovf_add_cout got %b expected 0", c); end
    run_op(OP_SUB, 16'h8000, 16'h0001, 1'b0, lat, bcnt, s, c, v);
    checks++; if (s !== 16'h7FFF) begin errors++; $display("FAIL ovf_sub_sum got %h expected 7fff", s); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL ovf_sub_ovf got %b expected 1", v); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL ovf_sub_cout got %b expected 1", c); end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.A = 16'h1111; bus.B = 16'h2222; bus.Ci = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    bus.start = 1'b1; bus.op = OP_SUB; bus.A = 16'hAAAA; bus.B = 16'h5555; bus.Ci = 1'b1;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (bus.Sum !== 16'h3333) begin errors++; $display("FAIL ignore_sum got %h expected 3333", bus.Sum); end
    checks++; if (bus.Cout !== 1'b0) begin errors++; $display("FAIL ignore_cout got %b expected 0", bus.Cout); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL ignore_latency got %0d expected 5", lat); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.A = 16'h0001; bus.B = 16'h0002; bus.Ci = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_first_latency got %0d expected 5", lat); end
    checks++; if (bus.Sum !== 16'h0003) begin errors++; $display("FAIL b2b_first_sum got %h expected 0003", bus.Sum); end
    bus.A = 16'h0010; bus.B = 16'h0020;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle got %b expected 1", bus.busy); end
    checks++; if (bus.Sum !== 16'h0000) begin errors++; $display("FAIL b2b_sum_cleared got %h expected 0000", bus.Sum); end
    bus.start = 1'b0;
    lat2 = 1;
    while (!bus.done && lat2 < 20) begin
      @(negedge clk);
      lat2++;
    end
    checks++; if (lat2 !== 5) begin errors++; $display("FAIL b2b_second_gap got %0d expected 5", lat2); end
    checks++; if (bus.Sum !== 16'h0030) begin errors++; $display("FAIL b2b_second_sum got %h expected 0030", bus.Sum); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt; logic [15:0] s; logic c, v;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.A = 16'h1234; bus.B = 16'h1111; bus.Ci = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.Sum !== 16'h0005) begin errors++; $display("FAIL midrst_partial got %h expected 0005", bus.Sum); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b expected 0", bus.done); end
    checks++; if (bus.Sum !== 16'h0000) begin errors++; $display("FAIL midrst_sum got %h expected 0000", bus.Sum); end
    checks++; if (bus.Cout !== 1'b0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL midrst_flags got %b%b expected 00", bus.Cout, bus.ovf); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b%b expected 00", bus.busy, bus.done); end
    run_op(OP_ADD, 16'h1234, 16'h1111, 1'b0, lat, bcnt, s, c, v);
    checks++; if (s !== 16'h2345) begin errors++; $display("FAIL midrst_rerun_sum got %h expected 2345", s); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_rerun_latency got %0d expected 5", lat); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_chain();
    test_sub();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
